// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder
// ----------------------------------------------------------------------------
// Multi-cycle data-memory responder for the core's load/store port. One
// request is accepted per handshake, a fixed number of wait states elapse,
// the 64-bit word array is read or written (byte/half/word/dword), and the
// response is held until the core accepts it.
//
// Parameters
//   DEPTH_WORDS : number of 64-bit words (power of two, 2..4096)
//   LATENCY     : wait cycles between acceptance and the array access (0..7)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_size   in   0 = byte, 1 = half, 2 = word, 3 = dword
//   req_wdata  in   store data, right-justified
//   rsp_valid  out  response present
//   rsp_ready  in   core accepts the response
//   rsp_rdata  out  load data, right-justified, zero-extended
//   rsp_err    out  access fault (out of range, or misaligned when checked)
//
// Build option
//   DMEM_MISALIGN_CHECK_EN : when defined, an access whose address is not a
//   multiple of its size faults. When undefined, the low address bits below
//   the access size are ignored.
// ============================================================================
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    // The access works from the captured request, so one capture cycle is
    // followed by LATENCY wait cycles; the counter is sized for LATENCY+1.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Byte-lane mask of an access of the given size, anchored at lane 0.
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            2'd0:    m = 3'b000;
            2'd1:    m = 3'b001;
            2'd2:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // Expand a per-byte enable into a per-bit mask.
    function automatic logic [63:0] expand_mask(input logic [7:0] be);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        we_r;
    logic [63:0] addr_r;
    logic [1:0]  size_r;
    logic [63:0] wdata_r;
    logic [63:0] rdata_r;
    logic        err_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [63:0] mem_r [DEPTH_WORDS];

    logic        accept_s;
    logic        access_s;
    logic        rsp_done_s;
    logic [2:0]  off_s;
    logic        misalign_s;
    logic        range_err_s;
    logic        err_s;
    logic [IDX_W-1:0] word_idx_s;
    logic [63:0] cur_word_s;
    logic [7:0]  be_s;
    logic [63:0] wmask_s;
    logic [63:0] wr_word_s;
    logic [63:0] rd_s;

    assign accept_s   = (state_r == ST_IDLE) && req_valid && req_ready_r;
    assign access_s   = (state_r == ST_WAIT) && (cnt_r == 4'd1);
    assign rsp_done_s = (state_r == ST_RESP) && rsp_ready;

    // Address decode and data lane steering for the captured request.
    always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
        off_s      = addr_r[2:0];
        misalign_s = |(addr_r[2:0] & align_mask(size_r));
`else
        off_s      = addr_r[2:0] & ~align_mask(size_r);
        misalign_s = 1'b0;
`endif
        range_err_s = |addr_r[63:IDX_W+3];
        err_s       = range_err_s | misalign_s;
        word_idx_s  = addr_r[IDX_W+2:3];
        cur_word_s  = mem_r[word_idx_s];
        be_s        = lane_mask(size_r) << off_s;
        wmask_s     = expand_mask(be_s);
        wr_word_s   = (cur_word_s & ~wmask_s) | ((wdata_r << {off_s, 3'b000}) & wmask_s);
        rd_s        = (cur_word_s >> {off_s, 3'b000}) & expand_mask(lane_mask(size_r));
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_WAIT;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s = ST_RESP;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and handshake outputs; outputs are decoded from the next
    // state so they are registered yet aligned with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            req_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
        end
    end

    // Request capture and response data; data is cleared once consumed so a
    // stale load value never lingers on the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_r    <= 1'b0;
            addr_r  <= 64'd0;
            size_r  <= 2'd0;
            wdata_r <= 64'd0;
            rdata_r <= 64'd0;
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                size_r  <= req_size;
                wdata_r <= req_wdata;
            end
            if (access_s) begin
                rdata_r <= (we_r || err_s) ? 64'd0 : rd_s;
                err_r   <= err_s;
            end else if (rsp_done_s) begin
                rdata_r <= 64'd0;
                err_r   <= 1'b0;
            end
        end
    end

    // Word array; contents survive reset, and the write is gated by the
    // state register so a reset before the access drops the store.
    always_ff @(posedge clk) begin
        if (access_s && we_r && !err_s) begin
            mem_r[word_idx_s] <= wr_word_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: unit 0 (LATENCY=2) carries the
// directed and randomized traffic, unit 1 (LATENCY=3) the mid-transaction reset.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int BYTES = DEPTH * 8;
    int lat_cfg [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [63:0] req_addr  [2];
    logic [1:0]  req_size  [2];
    logic [63:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int cmp_count = 0;
    int mis_count = 0;

    logic [7:0] mem_m [BYTES];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
        .clk(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
        .clk(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Byte-array reference: 2^size bytes at the (aligned) address.
    task automatic model_access(input logic we, input logic [63:0] addr, input logic [1:0] size,
                                input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
        int n;
        int base;
        n = 1 << size;
        rdata = 64'd0;
        err = 1'b0;
        if (addr >= 64'(BYTES)) err = 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((addr % 64'(n)) != 64'd0) err = 1'b1;
`endif
        if (!err) begin
            base = int'(addr - (addr % 64'(n)));
            for (int i = 0; i < n; i++) begin
                if (we) mem_m[base + i] = wdata[8*i +: 8];
                else    rdata[8*i +: 8] = mem_m[base + i];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction; reports data, error, edges from acceptance to
    // rsp_valid (-1 on timeout) and whether the handshake rules held.
    task automatic xact(input int u, input logic we, input logic [63:0] addr, input logic [1:0] size,
                        input logic [63:0] wdata, input int hold, input logic intrude,
                        output logic [63:0] rdata, output logic err, output int lat, output logic ok);
        logic [63:0] rd0;
        logic        er0;
        ok = 1'b1; lat = -1; rdata = 64'd0; err = 1'b0;
        for (int i = 0; i < 20 && req_ready[u] !== 1'b1; i++) tick();
        req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr;
        req_size[u] = size; req_wdata[u] = wdata;
        tick();
        req_valid[u] = 1'b0;
        if (req_ready[u] !== 1'b0 || rsp_valid[u] !== 1'b0) ok = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (rsp_valid[u] === 1'b1) begin
                lat = c;
                break;
            end
            if (req_ready[u] !== 1'b0) ok = 1'b0;
        end
        if (lat < 0) return;
        rd0 = rsp_rdata[u]; er0 = rsp_err[u];
        rdata = rd0; err = er0;
        if (intrude) begin
            req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = 64'h10;
            req_size[u] = 2'd3; req_wdata[u] = 64'hDEAD_BEEF_DEAD_BEEF;
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready[u] = 1'b0;
            tick();
            if (rsp_valid[u] !== 1'b1 || rsp_rdata[u] !== rd0 || rsp_err[u] !== er0 || req_ready[u] !== 1'b0)
                ok = 1'b0;
        end
        rsp_ready[u] = 1'b1;
        tick();
        rsp_ready[u] = 1'b0;
        req_valid[u] = 1'b0;
        if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = 64'd0;
            req_size[u] = 2'd0; req_wdata[u] = 64'd0; rsp_ready[u] = 1'b0;
        end
        tick(); tick();
        for (int u = 0; u < 2; u++) begin
            cmp_count++;
            if ({req_ready[u], rsp_valid[u], rsp_err[u], rsp_rdata[u]} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
                mis_count++;
                $display("FAIL reset_out[%0d]: got rdy=%b vld=%b err=%b rd=%h expected 1 0 0 0", u,
                         req_ready[u], rsp_valid[u], rsp_err[u], rsp_rdata[u]);
            end
            rst_n[u] = 1'b1;
        end
        tick();
        cmp_count++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            mis_count++;
            $display("FAIL after_reset: got rdy=%b vld=%b expected 1 0", req_ready[0], rsp_valid[0]);
        end
    endtask

    task automatic test_dword();
        logic [63:0] rd; logic er; int lat; logic ok;
        xact(0, 1'b1, 64'h10, 2'd3, 64'h1122334455667788, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (er !== 1'b0 || rd !== 64'd0) begin mis_count++; $display("FAIL sd_rsp: got err=%b rd=%h expected 0 0", er, rd); end
        cmp_count++;
        if (lat !== 3) begin mis_count++; $display("FAIL sd_latency: got %0d expected 3", lat); end
        cmp_count++;
        if (ok !== 1'b1) begin mis_count++; $display("FAIL sd_protocol: got %b expected 1", ok); end
        xact(0, 1'b0, 64'h10, 2'd3, 64'd0, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (rd !== 64'h1122334455667788 || er !== 1'b0) begin
            mis_count++; $display("FAIL ld_dword: got %h err=%b expected 1122334455667788 0", rd, er);
        end
        cmp_count++;
        if (lat !== 3 || ok !== 1'b1) begin mis_count++; $display("FAIL ld_timing: got lat=%0d ok=%b expected 3 1", lat, ok); end
    endtask

    task automatic test_subword();
        logic [63:0] rd; logic er; int lat; logic ok;
        xact(0, 1'b1, 64'h13, 2'd0, 64'h00000000000000AB, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (er !== 1'b0) begin mis_count++; $display("FAIL sb_err: got %b expected 0", er); end
        xact(0, 1'b0, 64'h10, 2'd3, 64'd0, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (rd !== 64'h11223344AB667788) begin mis_count++; $display("FAIL ld_after_sb: got %h expected 11223344ab667788", rd); end
        xact(0, 1'b0, 64'h12, 2'd1, 64'd0, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (rd !== 64'h000000000000AB66 || er !== 1'b0) begin
            mis_count++; $display("FAIL lh: got %h err=%b expected 000000000000ab66 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] rd; logic er; int lat; logic ok; int spurious;
        xact(0, 1'b0, 64'h10, 2'd3, 64'd0, 5, 1'b1, rd, er, lat, ok);
        cmp_count++;
        if (ok !== 1'b1) begin mis_count++; $display("FAIL bp_stable: got %b expected 1", ok); end
        cmp_count++;
        if (rd !== 64'h11223344AB667788) begin mis_count++; $display("FAIL bp_data: got %h expected 11223344ab667788", rd); end
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) spurious++;
        end
        cmp_count++;
        if (spurious !== 0) begin mis_count++; $display("FAIL bp_ignored_req: got %0d busy cycles expected 0", spurious); end
        xact(0, 1'b0, 64'h10, 2'd3, 64'd0, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (rd !== 64'h11223344AB667788) begin mis_count++; $display("FAIL bp_no_write: got %h expected 11223344ab667788", rd); end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic er; int lat; logic ok;
        xact(0, 1'b1, 64'h1F8, 2'd3, 64'hCAFE0123456789AA, 0, 1'b0, rd, er, lat, ok);
        xact(0, 1'b1, 64'h200, 2'd3, 64'h5555AAAA5555AAAA, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (er !== 1'b1 || rd !== 64'd0) begin mis_count++; $display("FAIL oor_err: got err=%b rd=%h expected 1 0", er, rd); end
        cmp_count++;
        if (lat !== 3) begin mis_count++; $display("FAIL oor_latency: got %0d expected 3", lat); end
        xact(0, 1'b0, 64'h1F8, 2'd3, 64'd0, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (rd !== 64'hCAFE0123456789AA || er !== 1'b0) begin
            mis_count++; $display("FAIL oor_no_write: got %h err=%b expected cafe0123456789aa 0", rd, er);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] rd; logic er; int lat; logic ok;
        logic [63:0] exp_rd; logic exp_er;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_rd = 64'd0; exp_er = 1'b1;
`else
        exp_rd = 64'h00000000AB667788; exp_er = 1'b0;
`endif
        xact(0, 1'b0, 64'h12, 2'd2, 64'd0, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (rd !== exp_rd || er !== exp_er) begin
            mis_count++; $display("FAIL lw_misalign: got %h err=%b expected %h %b", rd, er, exp_rd, exp_er);
        end
        cmp_count++;
        if (lat !== 3) begin mis_count++; $display("FAIL lw_misalign_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd; logic er; int lat; logic ok;
        xact(1, 1'b1, 64'h08, 2'd3, 64'h0123456789ABCDEF, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (lat !== 4 || ok !== 1'b1) begin mis_count++; $display("FAIL lat3_timing: got lat=%0d ok=%b expected 4 1", lat, ok); end
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 64'h08;
        req_size[1] = 2'd3; req_wdata[1] = 64'h00000000000000FF;
        tick();
        req_valid[1] = 1'b0;
        tick();
        rst_n[1] = 1'b0;
        #1;
        cmp_count++;
        if ({req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]} !== {1'b1, 1'b0, 1'b0, 64'd0}) begin
            mis_count++;
            $display("FAIL mid_reset_out: got rdy=%b vld=%b err=%b rd=%h expected 1 0 0 0",
                     req_ready[1], rsp_valid[1], rsp_err[1], rsp_rdata[1]);
        end
        tick(); tick();
        rst_n[1] = 1'b1;
        tick();
        xact(1, 1'b0, 64'h08, 2'd3, 64'd0, 0, 1'b0, rd, er, lat, ok);
        cmp_count++;
        if (rd !== 64'h0123456789ABCDEF) begin mis_count++; $display("FAIL mid_reset_dropped: got %h expected 0123456789abcdef", rd); end
    endtask

    task automatic test_random();
        logic [63:0] rd, exp_rd, wd, a; logic er, exp_er, we; logic [1:0] sz; int lat; logic ok;
        for (int w = 0; w < DEPTH; w++) begin
            wd = {$urandom, $urandom};
            model_access(1'b1, 64'(w * 8), 2'd3, wd, exp_rd, exp_er);
            xact(0, 1'b1, 64'(w * 8), 2'd3, wd, 0, 1'b0, rd, er, lat, ok);
            cmp_count++;
            if (er !== exp_er || lat !== 3) begin
                mis_count++; $display("FAIL rnd_init[%0d]: got err=%b lat=%0d expected %b 3", w, er, lat, exp_er);
            end
        end
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            wd = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       a = 64'(BYTES + $urandom_range(0, 63));
                1:       a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
                default: a = 64'($urandom_range(0, BYTES - 1));
            endcase
            model_access(we, a, sz, wd, exp_rd, exp_er);
            xact(0, we, a, sz, wd, int'($urandom_range(0, 3)), 1'b0, rd, er, lat, ok);
            cmp_count++;
            if (rd !== exp_rd || er !== exp_er || lat !== 3 || ok !== 1'b1) begin
                mis_count++;
                $display("FAIL rnd[%0d] we=%b sz=%0d a=%h: got rd=%h err=%b lat=%0d ok=%b expected rd=%h err=%b lat=3 ok=1",
                         t, we, sz, a, rd, er, lat, ok, exp_rd, exp_er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dword();
        test_subword();
        test_backpressure();
        test_out_of_range();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
